// File: rtl/mem_bus_arbiter.sv
// Round-robin two-port arbiter and sequencer for the shared A2/D2/C2 RAM bus.
// Runs one line transaction at a time; a watchdog aborts transactions the RAM never answers.
//   state   | meaning
//   IDLE    | waiting for a request, grants on the next edge
//   CMD     | drives C2 command, A2 address
//   RD_WAIT | buses released, waiting for first RAM response
//   RD_DATA | capturing read beats on each C2 response
//   WR_DATA | drives D2 write beats back to back
//   WR_WAIT | buses released, waiting for RAM write ack
//   DONE    | one-cycle completion pulse
module mem_bus_arbiter #(
  parameter int ADDR2_BUS_SIZE = 10,
  parameter int DATA2_BUS_SIZE = 16,
  parameter int CTR2_BUS_SIZE  = 2,
  parameter int LINE_BEATS     = 8,
  parameter int TIMEOUT        = 64
) (
  input  logic                      clk,
  input  logic                      RESET,
  input  logic [1:0]                req_valid,
  input  logic [1:0]                req_write,
  input  logic [ADDR2_BUS_SIZE-1:0] req_addr0,
  input  logic [ADDR2_BUS_SIZE-1:0] req_addr1,
  input  logic [DATA2_BUS_SIZE-1:0] req_wdata0,
  input  logic [DATA2_BUS_SIZE-1:0] req_wdata1,
  output logic [1:0]                wready,
  output logic [DATA2_BUS_SIZE-1:0] rdata,
  output logic [1:0]                rvalid,
  output logic [1:0]                done,
  output logic [1:0]                err,
  output logic [ADDR2_BUS_SIZE-1:0] A2,
  inout  wire  [DATA2_BUS_SIZE-1:0] D2,
  inout  wire  [CTR2_BUS_SIZE-1:0]  C2
);

  localparam logic [CTR2_BUS_SIZE-1:0] C2_RESPONSE   = CTR2_BUS_SIZE'(1);
  localparam logic [CTR2_BUS_SIZE-1:0] C2_READ_LINE  = CTR2_BUS_SIZE'(2);
  localparam logic [CTR2_BUS_SIZE-1:0] C2_WRITE_LINE = CTR2_BUS_SIZE'(3);
  localparam int BEAT_W = $clog2(LINE_BEATS);
  localparam int TMR_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, CMD, RD_WAIT, RD_DATA, WR_DATA, WR_WAIT, DONE
  } state_t;

  state_t            state, state_nxt;
  logic              port, rr_last, write_q;
  logic              grant, gnt_port;
  logic [BEAT_W-1:0] beat;
  logic [TMR_W-1:0]  timer;
  logic              rsp, last_beat, timeout_hit;
  logic [1:0]        port_oh;

  assign rsp         = (C2 == C2_RESPONSE);
  assign last_beat   = (beat == BEAT_W'(LINE_BEATS - 1));
  assign timeout_hit = (timer == TMR_W'(TIMEOUT - 1));
  assign port_oh     = port ? 2'b10 : 2'b01;

  // Only CMD drives C2 and only WR_DATA drives D2, so the two are never driven together.
  assign C2 = (state == CMD) ? (write_q ? C2_WRITE_LINE : C2_READ_LINE) : 'z;
  assign D2 = (state == WR_DATA) ? (port ? req_wdata1 : req_wdata0) : 'z;

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    gnt_port  = 1'b0;
    wready    = 2'b00;
    done      = 2'b00;
    err       = 2'b00;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          grant     = 1'b1;
          gnt_port  = (&req_valid) ? ~rr_last : req_valid[1];
          state_nxt = CMD;
        end
      end
      CMD: state_nxt = write_q ? WR_DATA : RD_WAIT;
      RD_WAIT: begin
        if (rsp) begin
          state_nxt = RD_DATA;
        end else if (timeout_hit) begin
          err       = port_oh;
          state_nxt = IDLE;
        end
      end
      RD_DATA: begin
        if (rsp && last_beat) state_nxt = DONE;
      end
      WR_DATA: begin
        wready = port_oh;
        if (last_beat) state_nxt = WR_WAIT;
      end
      WR_WAIT: begin
        if (rsp) begin
          state_nxt = DONE;
        end else if (timeout_hit) begin
          err       = port_oh;
          state_nxt = IDLE;
        end
      end
      DONE: begin
        done      = port_oh;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state   <= IDLE;
      port    <= 1'b0;
      rr_last <= 1'b1;
      write_q <= 1'b0;
      A2      <= '0;
      beat    <= '0;
      timer   <= '0;
      rdata   <= '0;
      rvalid  <= 2'b00;
    end else begin
      state  <= state_nxt;
      rvalid <= 2'b00;
      if (grant) begin
        port    <= gnt_port;
        rr_last <= gnt_port;
        write_q <= req_write[gnt_port];
        A2      <= gnt_port ? req_addr1 : req_addr0;
      end
      if (state == CMD) begin
        beat  <= '0;
        timer <= '0;
      end
      if ((state == RD_WAIT || state == WR_WAIT) && !rsp) timer <= timer + 1'b1;
      // The first response in RD_WAIT is already beat 0 of the burst.
      if ((state == RD_WAIT || state == RD_DATA) && rsp) begin
        rdata  <= D2;
        rvalid <= port_oh;
        beat   <= beat + 1'b1;
      end
      if (state == WR_DATA) beat <= beat + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: the bench plays both requesters and the RAM on A2/D2/C2.
module tb_mem_bus_arbiter;
  localparam int TIMEOUT = 64;
  localparam int LINE_BEATS = 8;
  localparam logic [1:0] NOP = 2'd0, RSP = 2'd1, RD = 2'd2, WR = 2'd3;

  logic        clk = 1'b0;
  logic        RESET = 1'b0;
  logic [1:0]  req_valid = 2'b00, req_write = 2'b00;
  logic [9:0]  req_addr0 = '0, req_addr1 = '0;
  logic [15:0] req_wdata0 = '0, req_wdata1 = '0;
  logic [1:0]  wready, rvalid, done, err;
  logic [15:0] rdata;
  logic [9:0]  A2;
  wire  [15:0] D2;
  wire  [1:0]  C2;

  logic        d2_en = 1'b0, c2_en = 1'b0;
  logic [15:0] d2_drv = '0;
  logic [1:0]  c2_drv = '0;
  assign D2 = d2_en ? d2_drv : 'z;
  assign C2 = c2_en ? c2_drv : 'z;

  int errors = 0;
  int checks = 0;

  mem_bus_arbiter #(.TIMEOUT(TIMEOUT), .LINE_BEATS(LINE_BEATS)) dut (
    .clk(clk), .RESET(RESET), .req_valid(req_valid), .req_write(req_write),
    .req_addr0(req_addr0), .req_addr1(req_addr1), .req_wdata0(req_wdata0),
    .req_wdata1(req_wdata1), .wready(wready), .rdata(rdata), .rvalid(rvalid),
    .done(done), .err(err), .A2(A2), .D2(D2), .C2(C2)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] mem_word(input logic [9:0] a, input int k);
    return {a[7:0], 8'(k)} ^ 16'h5A00;
  endfunction

  // Starts in the IDLE cycle with the request already raised; ends in the following IDLE cycle.
  task automatic do_read(input int p, input logic [9:0] addr, input int nops,
                         input int stall_at, input bit drop);
    logic [1:0] oh;
    int k, pk;
    bit pv;
    oh = (p == 1) ? 2'b10 : 2'b01;
    tick();
    chk("rd_cmd_c2", C2, RD);
    chk("rd_cmd_a2", A2, addr);
    for (int i = 0; i < nops; i++) begin
      tick();
      c2_en = 1'b1; c2_drv = NOP;
      d2_en = 1'b1; d2_drv = 16'h5AA5;
      #1;
      if (i == 0) begin
        chk("rd_wait_c2_released", C2, NOP);
        chk("rd_wait_d2_released", D2, 16'h5AA5);
      end
      chk("rd_wait_rvalid", rvalid, 2'b00);
      chk("rd_wait_err", err, 2'b00);
      chk("rd_wait_a2", A2, addr);
    end
    k = 0; pk = 0; pv = 1'b0;
    for (int c = 0; c < LINE_BEATS + ((stall_at >= 0) ? 1 : 0); c++) begin
      tick();
      if (pv) begin
        chk("rd_rvalid", rvalid, oh);
        chk("rd_rdata", rdata, mem_word(addr, pk));
      end else begin
        chk("rd_rvalid_idle", rvalid, 2'b00);
      end
      chk("rd_data_a2", A2, addr);
      chk("rd_data_done", done, 2'b00);
      c2_en = 1'b1; d2_en = 1'b1;
      if (c == stall_at) begin
        c2_drv = NOP; pv = 1'b0;
      end else begin
        c2_drv = RSP; d2_drv = mem_word(addr, k); pv = 1'b1; pk = k; k++;
      end
    end
    tick();
    c2_en = 1'b0; d2_en = 1'b0;
    chk("rd_last_rvalid", rvalid, oh);
    chk("rd_last_rdata", rdata, mem_word(addr, LINE_BEATS - 1));
    chk("rd_done", done, oh);
    chk("rd_done_err", err, 2'b00);
    chk("rd_done_a2", A2, addr);
    if (drop) req_valid[p] = 1'b0;
    tick();
    chk("rd_idle_done", done, 2'b00);
    chk("rd_idle_rvalid", rvalid, 2'b00);
  endtask

  task automatic do_write(input int p, input logic [9:0] addr, input logic [15:0] base,
                          input bit drop);
    logic [1:0] oh;
    oh = (p == 1) ? 2'b10 : 2'b01;
    if (p == 1) req_wdata1 = base; else req_wdata0 = base;
    tick();
    chk("wr_cmd_c2", C2, WR);
    chk("wr_cmd_a2", A2, addr);
    chk("wr_cmd_wready", wready, 2'b00);
    for (int k = 0; k < LINE_BEATS; k++) begin
      tick();
      if (p == 1) req_wdata1 = base + 16'(k); else req_wdata0 = base + 16'(k);
      #1;
      chk("wr_wready", wready, oh);
      chk("wr_d2", D2, base + 16'(k));
      chk("wr_a2", A2, addr);
    end
    tick();
    c2_en = 1'b1; c2_drv = NOP;
    d2_en = 1'b1; d2_drv = 16'h3C3C;
    #1;
    chk("wr_wait_wready", wready, 2'b00);
    chk("wr_wait_c2_released", C2, NOP);
    chk("wr_wait_d2_released", D2, 16'h3C3C);
    tick();
    tick();
    tick();
    c2_drv = RSP;
    tick();
    c2_en = 1'b0; d2_en = 1'b0;
    chk("wr_done", done, oh);
    chk("wr_done_a2", A2, addr);
    if (drop) req_valid[p] = 1'b0;
    tick();
    chk("wr_idle_done", done, 2'b00);
  endtask

  initial begin
    #2;
    chk("rst_a2", A2, 10'd0);
    chk("rst_rvalid", rvalid, 2'b00);
    chk("rst_rdata", rdata, 16'd0);
    chk("rst_wready", wready, 2'b00);
    chk("rst_done", done, 2'b00);
    chk("rst_err", err, 2'b00);
    #16 RESET = 1'b1;
    tick();

    // port 0 read after 10 NOPs
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr0 = 10'h005;
    do_read(0, 10'h005, 10, -1, 1'b1);

    // port 1 write
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_addr1 = 10'h03A;
    do_write(1, 10'h03A, 16'h1000, 1'b1);

    // both held from reset: grants 0,1,0,1
    RESET = 1'b0;
    #2 RESET = 1'b1;
    req_write = 2'b10; req_addr0 = 10'h010; req_addr1 = 10'h02B;
    req_valid = 2'b11;
    do_read(0, 10'h010, 0, 4, 1'b0);
    do_write(1, 10'h02B, 16'h2000, 1'b0);
    do_read(0, 10'h010, 1, -1, 1'b1);
    do_write(1, 10'h02B, 16'h3000, 1'b1);
    chk("rr_all_dropped", req_valid, 2'b00);

    // RAM never answers
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr0 = 10'h011;
    tick();
    chk("to_cmd_c2", C2, RD);
    for (int i = 1; i <= TIMEOUT; i++) begin
      tick();
      c2_en = 1'b1; c2_drv = NOP;
      #1;
      if (i == TIMEOUT - 1) chk("to_err_early", err, 2'b00);
      if (i == TIMEOUT) begin
        chk("to_err", err, 2'b01);
        chk("to_done", done, 2'b00);
        chk("to_a2", A2, 10'h011);
        req_valid[0] = 1'b0;
      end
    end
    tick();
    c2_en = 1'b0;
    #1;
    chk("to_err_clear", err, 2'b00);
    chk("to_idle_done", done, 2'b00);
    req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr1 = 10'h022;
    do_read(1, 10'h022, 3, -1, 1'b1);

    // reset during read beat 3
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr0 = 10'h007;
    tick();
    chk("rst_mid_cmd", C2, RD);
    tick();
    c2_en = 1'b1; c2_drv = NOP;
    for (int k = 0; k < 4; k++) begin
      tick();
      c2_drv = RSP; d2_en = 1'b1; d2_drv = mem_word(10'h007, k);
    end
    #1;
    chk("rst_mid_pre_rvalid", rvalid, 2'b01);
    chk("rst_mid_pre_rdata", rdata, mem_word(10'h007, 2));
    RESET = 1'b0;
    c2_en = 1'b0; d2_en = 1'b0;
    #1;
    chk("rst_mid_rvalid", rvalid, 2'b00);
    chk("rst_mid_rdata", rdata, 16'd0);
    chk("rst_mid_a2", A2, 10'd0);
    chk("rst_mid_done", done, 2'b00);
    chk("rst_mid_err", err, 2'b00);
    tick();
    chk("rst_hold_done", done, 2'b00);
    chk("rst_hold_rvalid", rvalid, 2'b00);
    #2 RESET = 1'b1;
    do_read(0, 10'h007, 2, -1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
